spi_periph_shifter: RTL and testbench

- Mode-0 (CPOL=0, CPHA=0), MSB-first SPI peripheral byte engine.
- Samples SCLK, CSN and COPI from the D_IN_0 outputs of the pad cells in sys_clk.
- Drives CIPO data and output-enable into the CIPO pad's D_OUT_0 / OUTPUT_ENABLE.
- Presents whole bytes to fabric logic over valid/ready handshakes.
- SCLK is oversampled; sys_clk must be at least 4x the SCLK frequency.

---
 rtl/spi_periph_shifter.sv | 159 +++++++++++++++
 tb/tb_spi_periph_shifter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_periph_shifter.sv
// ---------------------------------------------------------------------------
// spi_periph_shifter
//   Mode-0 (CPOL=0, CPHA=0), MSB-first SPI peripheral byte engine. The pad
//   inputs are synchronized and oversampled in sys_clk (sys_clk >= 4x SCLK).
//   Whole bytes are exchanged with the fabric over valid/ready handshakes.
//
// Ports
//   sys_clk, sys_rst        system clock, synchronous active-high reset
//   sclk_i, csn_i, copi_i   SPI pins from pad D_IN_0
//   cipo_o, cipo_oe         CIPO pad D_OUT_0 / OUTPUT_ENABLE
//   tx_data/valid/ready     one-entry TX holding register
//   rx_data/valid/ready     received byte toward the consumer
//   tx_underrun             pulse: TX_IDLE substituted at a byte start
//   rx_overrun              pulse: received byte dropped (consumer not ready)
//   busy                    high while a frame is active
// ---------------------------------------------------------------------------
module spi_periph_shifter #(
   parameter int          SYNC_STAGES = 2,
   parameter logic [7:0]  TX_IDLE     = 8'hFF
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       sclk_i,
   input  logic       csn_i,
   input  logic       copi_i,
   output logic       cipo_o,
   output logic       cipo_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       tx_underrun,
   output logic       rx_overrun,
   output logic       busy
);

   typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

   state_t                 r_state;
   logic [SYNC_STAGES-1:0] r_sclk_sync, r_csn_sync, r_copi_sync;
   logic                   r_sclk_d, r_csn_d;
   logic [2:0]             r_cnt;
   // The TX shifter is {cipo_o, r_tx_sh}: the MSB lives in the output flop.
   logic [6:0]             r_tx_sh;
   // Received bits of the current byte; the 8th bit completes it directly.
   logic [6:0]             r_rx_sh;
   logic [7:0]             r_hold;
   logic                   r_hold_full;

   logic                   w_sclk, w_csn, w_copi;
   logic                   w_sclk_rise, w_sclk_fall, w_csn_rise, w_csn_fall;
   logic [7:0]             w_next_tx, w_rx_next;

   assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
   assign w_csn       = r_csn_sync[SYNC_STAGES-1];
   assign w_copi      = r_copi_sync[SYNC_STAGES-1];
   assign w_sclk_rise =  w_sclk & ~r_sclk_d;
   assign w_sclk_fall = ~w_sclk &  r_sclk_d;
   assign w_csn_rise  =  w_csn  & ~r_csn_d;
   assign w_csn_fall  = ~w_csn  &  r_csn_d;
   assign w_next_tx   = r_hold_full ? r_hold : TX_IDLE;
   assign w_rx_next   = {r_rx_sh, w_copi};
   assign tx_ready    = ~r_hold_full;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_state     <= ST_IDLE;
         r_sclk_sync <= '0;
         r_csn_sync  <= '1;
         r_copi_sync <= '0;
         r_sclk_d    <= 1'b0;
         r_csn_d     <= 1'b1;
         r_cnt       <= 3'd0;
         r_tx_sh     <= 7'd0;
         r_rx_sh     <= 7'd0;
         r_hold      <= 8'd0;
         r_hold_full <= 1'b0;
         cipo_o      <= 1'b1;
         cipo_oe     <= 1'b0;
         rx_data     <= 8'd0;
         rx_valid    <= 1'b0;
         tx_underrun <= 1'b0;
         rx_overrun  <= 1'b0;
         busy        <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_i};
         r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0],  csn_i};
         r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi_i};
         r_sclk_d    <= w_sclk;
         r_csn_d     <= w_csn;
         tx_underrun <= 1'b0;
         rx_overrun  <= 1'b0;

         // Consumer handshake; a byte landing this cycle overrides below.
         if (rx_valid && rx_ready)
            rx_valid <= 1'b0;

         // Holding register fill; it can only be consumed when full, so a
         // fill and a consume never coincide.
         if (tx_valid && !r_hold_full) begin
            r_hold      <= tx_data;
            r_hold_full <= 1'b1;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_csn_fall) begin
                  r_state <= ST_ACTIVE;
                  cipo_oe <= 1'b1;
                  busy    <= 1'b1;
                  r_cnt   <= 3'd0;
                  cipo_o  <= w_next_tx[7];
                  r_tx_sh <= w_next_tx[6:0];
                  if (r_hold_full) r_hold_full <= 1'b0;
                  else             tx_underrun <= 1'b1;
               end
            end
            ST_ACTIVE: begin
               if (w_csn_rise) begin
                  // Frame end wins over any sclk edge in the same cycle.
                  r_state <= ST_IDLE;
                  cipo_oe <= 1'b0;
                  busy    <= 1'b0;
                  r_cnt   <= 3'd0;
               end else begin
                  if (w_sclk_rise) begin
                     r_rx_sh <= w_rx_next[6:0];
                     r_cnt   <= r_cnt + 3'd1;
                     if (r_cnt == 3'd7) begin
                        if (!rx_valid || rx_ready) begin
                           rx_data  <= w_rx_next;
                           rx_valid <= 1'b1;
                        end else begin
                           rx_overrun <= 1'b1;
                        end
                     end
                  end
                  if (w_sclk_fall) begin
                     if (r_cnt != 3'd0) begin
                        cipo_o  <= r_tx_sh[6];
                        r_tx_sh <= {r_tx_sh[5:0], 1'b0};
                     end else begin
                        // Byte boundary: start the next TX byte.
                        cipo_o  <= w_next_tx[7];
                        r_tx_sh <= w_next_tx[6:0];
                        if (r_hold_full) r_hold_full <= 1'b0;
                        else             tx_underrun <= 1'b1;
                     end
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_periph_shifter.sv
module tb_spi_periph_shifter;

   logic       sys_clk = 1'b0;
   logic       sys_rst, sclk_i, csn_i, copi_i;
   logic       cipo_o, cipo_oe, tx_ready, rx_valid, rx_ready;
   logic       tx_valid, tx_underrun, rx_overrun, busy;
   logic [7:0] tx_data, rx_data;

   always #5 sys_clk = ~sys_clk;

   spi_periph_shifter #(.SYNC_STAGES(2), .TX_IDLE(8'hFF)) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .sclk_i     (sclk_i),
      .csn_i      (csn_i),
      .copi_i     (copi_i),
      .cipo_o     (cipo_o),
      .cipo_oe    (cipo_oe),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .tx_underrun(tx_underrun),
      .rx_overrun (rx_overrun),
      .busy       (busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   // Event monitor: pulses, rx_valid-high cycles, accepted bytes.
   int         n_und = 0, n_ovr = 0, n_rxv = 0;
   logic [7:0] acc_q[$];
   always @(posedge sys_clk) begin
      if (tx_underrun)           n_und++;
      if (rx_overrun)            n_ovr++;
      if (rx_valid)              n_rxv++;
      if (rx_valid && rx_ready)  acc_q.push_back(rx_data);
   end

   task automatic push_tx(input logic [7:0] d);
      @(negedge sys_clk); tx_data = d; tx_valid = 1'b1;
      @(negedge sys_clk); tx_valid = 1'b0;
   endtask

   task automatic csn_low();
      @(negedge sys_clk); csn_i = 1'b0;
      repeat (6) @(negedge sys_clk);
   endtask

   // One SPI bit at sys_clk/8; optionally ends the frame on the final fall.
   task automatic spi_bit(input logic b, input logic end_frame, output logic m);
      copi_i = b;
      repeat (4) @(negedge sys_clk);
      m = cipo_o;
      sclk_i = 1'b1;
      repeat (4) @(negedge sys_clk);
      sclk_i = 1'b0;
      if (end_frame) csn_i = 1'b1;
   endtask

   task automatic xfer(input logic [7:0] mosi, input logic end_frame, output logic [7:0] miso);
      logic m;
      for (int i = 7; i >= 0; i--) begin
         spi_bit(mosi[i], end_frame && (i == 0), m);
         miso[i] = m;
      end
      repeat (6) @(negedge sys_clk);
   endtask

   initial begin
      logic [7:0] miso;
      int         und0, ovr0, rxv0, acc0, k;
      logic       ok;

      sys_rst = 1'b1; sclk_i = 1'b0; csn_i = 1'b1; copi_i = 1'b0;
      tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0;

      // ---- reset with toggling pins
      repeat (3) begin
         @(negedge sys_clk);
         sclk_i = ~sclk_i; csn_i = ~csn_i; copi_i = ~copi_i;
      end
      @(negedge sys_clk);
      sclk_i = 1'b0; csn_i = 1'b1; copi_i = 1'b0;
      chk("rst_cipo",     cipo_o,      1);
      chk("rst_cipo_oe",  cipo_oe,     0);
      chk("rst_tx_ready", tx_ready,    1);
      chk("rst_rx_valid", rx_valid,    0);
      chk("rst_rx_data",  rx_data,     0);
      chk("rst_underrun", tx_underrun, 0);
      chk("rst_overrun",  rx_overrun,  0);
      chk("rst_busy",     busy,        0);
      @(negedge sys_clk); sys_rst = 1'b0;
      repeat (3) @(negedge sys_clk);
      chk("post_rst_busy", busy, 0);

      // ---- single byte: A5 out, 3C in
      und0 = n_und; ovr0 = n_ovr;
      push_tx(8'hA5);
      chk("t1_tx_ready_full", tx_ready, 0);
      csn_low();
      chk("t1_busy",     busy,     1);
      chk("t1_cipo_oe",  cipo_oe,  1);
      chk("t1_tx_ready", tx_ready, 1);
      xfer(8'h3C, 1'b1, miso);
      chk("t1_miso",     miso,     8'hA5);
      chk("t1_rx_data",  rx_data,  8'h3C);
      chk("t1_rx_valid", rx_valid, 1);
      chk("t1_cipo_oe_end", cipo_oe, 0);
      chk("t1_underrun", n_und - und0, 0);
      chk("t1_overrun",  n_ovr - ovr0, 0);
      @(negedge sys_clk); rx_ready = 1'b1;
      @(negedge sys_clk); rx_ready = 1'b0;
      chk("t1_rx_valid_drop", rx_valid, 0);

      // ---- back-to-back: 12,34 out; 55,AA in with rx_ready held
      und0 = n_und; acc0 = acc_q.size();
      rx_ready = 1'b1;
      push_tx(8'h12);
      csn_low();
      ok = 1'b0;
      for (k = 0; k < 50 && !ok; k++) begin
         if (tx_ready) ok = 1'b1;
         else @(negedge sys_clk);
      end
      chk("t2_tx_ready_wait", ok, 1);
      push_tx(8'h34);
      xfer(8'h55, 1'b0, miso);
      chk("t2_miso0", miso, 8'h12);
      xfer(8'hAA, 1'b1, miso);
      chk("t2_miso1", miso, 8'h34);
      chk("t2_acc_cnt", acc_q.size() - acc0, 2);
      if (acc_q.size() - acc0 == 2) begin
         chk("t2_acc0", acc_q[acc0],     8'h55);
         chk("t2_acc1", acc_q[acc0 + 1], 8'hAA);
      end
      chk("t2_underrun", n_und - und0, 0);
      rx_ready = 1'b0;

      // ---- underrun: nothing preloaded
      chk("t3_tx_ready", tx_ready, 1);
      und0 = n_und;
      csn_low();
      chk("t3_underrun_at_fall", n_und - und0, 1);
      xfer(8'h00, 1'b1, miso);
      chk("t3_miso",     miso, 8'hFF);
      chk("t3_underrun", n_und - und0, 1);
      chk("t3_rx_data",  rx_data, 8'h00);
      @(negedge sys_clk); rx_ready = 1'b1;
      @(negedge sys_clk); rx_ready = 1'b0;

      // ---- overrun: 01 then 02 with rx_ready low
      ovr0 = n_ovr;
      csn_low();
      xfer(8'h01, 1'b0, miso);
      chk("t4_ovr_first", n_ovr - ovr0, 0);
      xfer(8'h02, 1'b1, miso);
      chk("t4_rx_data",  rx_data,  8'h01);
      chk("t4_rx_valid", rx_valid, 1);
      chk("t4_overrun",  n_ovr - ovr0, 1);
      @(negedge sys_clk); rx_ready = 1'b1;
      @(negedge sys_clk); rx_ready = 1'b0;
      chk("t4_rx_valid_drop", rx_valid, 0);

      // ---- abort after 3 rises, then a fresh C3 frame
      rxv0 = n_rxv; ovr0 = n_ovr;
      csn_low();
      for (int i = 0; i < 3; i++) spi_bit(1'b1, 1'b0, miso[0]);
      repeat (2) @(negedge sys_clk);
      csn_i = 1'b1;
      ok = 1'b0;
      for (k = 0; k < 4 && !ok; k++) begin
         @(negedge sys_clk);
         if (!cipo_oe) ok = 1'b1;
      end
      chk("t5_oe_low", ok, 1);
      repeat (10) @(negedge sys_clk);
      chk("t5_no_rxv",  n_rxv - rxv0, 0);
      chk("t5_busy",    busy, 0);
      csn_low();
      xfer(8'hC3, 1'b1, miso);
      chk("t5_rx_data",  rx_data,  8'hC3);
      chk("t5_rx_valid", rx_valid, 1);
      chk("t5_overrun",  n_ovr - ovr0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
